neuron_backprop784: RTL and testbench

Backward-pass counterpart of the 784-input forward neuron. It takes the neuron's output error and its sigmoid derivative, and forms delta = err*sigma_prime. It then streams the 784 (prev_activ, weight) pairs once, and for each pair emits the updated weight and the back-propagated error term delta*w_old for the previous layer. It also produces the updated bias. It sits between the forward neuron's weight store and the previous layer's error accumulator.

---
 rtl/neuron_backprop784.sv | 138 +++++++++++++
 tb/tb_neuron_backprop784.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/neuron_backprop784.sv
// Backward pass for a 784-input neuron in Q8.24: computes delta = err*sigma', the updated
// bias, and streams updated weights plus back-propagated error terms (delta*w_old).
module neuron_backprop784 #(
    parameter int N    = 784,
    parameter int W    = 32,
    parameter int FRAC = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic signed [W-1:0] err_in,
    input  logic signed [W-1:0] sigma_prime,
    input  logic signed [W-1:0] bias_in,
    input  logic signed [W-1:0] lr,
    output logic                busy,
    output logic                done,
    output logic signed [W-1:0] delta_out,
    output logic signed [W-1:0] bias_out,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] in_activ,
    input  logic signed [W-1:0] in_weight,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [W-1:0] out_weight,
    output logic signed [W-1:0] out_back_err,
    output logic                out_last
);

    localparam int IDX_W = $clog2(N + 1);
    localparam logic signed [W-1:0] MAX_V = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] MIN_V = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, DELTA, STREAM, DONE} state_t;

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic signed [W-1:0] err_p0, sp_p0, bias_p0, lr_p0;

    // Clamp a wide value into the W-bit range: in range iff all bits above the sign agree.
    function automatic logic signed [W-1:0] sat_w(input logic signed [2*W-1:0] x);
        if (&x[2*W-1:W-1] || ~|x[2*W-1:W-1])
            return x[W-1:0];
        else
            return x[2*W-1] ? MIN_V : MAX_V;
    endfunction

    // Fixed-point multiply; the arithmetic shift floors toward -inf.
    function automatic logic signed [W-1:0] mul(input logic signed [W-1:0] a,
                                                 input logic signed [W-1:0] b);
        logic signed [2*W-1:0] p;
        p = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
        return sat_w(p >>> FRAC);
    endfunction

    function automatic logic signed [W-1:0] sub_sat(input logic signed [W-1:0] a,
                                                    input logic signed [W-1:0] b);
        logic signed [W:0] d;
        d = $signed({a[W-1], a}) - $signed({b[W-1], b});
        if (d[W] != d[W-1])
            return d[W] ? MIN_V : MAX_V;
        else
            return d[W-1:0];
    endfunction

    logic signed [W-1:0] delta_calc, new_weight, back_err;
    logic                in_hs, out_hs;

    assign delta_calc = mul(err_p0, sp_p0);
    assign new_weight = sub_sat(in_weight, mul(lr_p0, mul(delta_out, in_activ)));
    assign back_err   = mul(delta_out, in_weight);

    assign busy     = (state != IDLE);
    assign in_ready = (state == STREAM) && (idx != IDX_W'(N)) && (!out_valid || out_ready);
    assign in_hs    = in_valid && in_ready;
    assign out_hs   = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            idx          <= '0;
            done         <= 1'b0;
            err_p0       <= '0;
            sp_p0        <= '0;
            bias_p0      <= '0;
            lr_p0        <= '0;
            delta_out    <= '0;
            bias_out     <= '0;
            out_valid    <= 1'b0;
            out_weight   <= '0;
            out_back_err <= '0;
            out_last     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        err_p0  <= err_in;
                        sp_p0   <= sigma_prime;
                        bias_p0 <= bias_in;
                        lr_p0   <= lr;
                        state   <= DELTA;
                    end
                end
                // Delta and bias update, one cycle
                DELTA: begin
                    delta_out <= delta_calc;
                    bias_out  <= sub_sat(bias_p0, mul(lr_p0, delta_calc));
                    idx       <= '0;
                    state     <= STREAM;
                end
                // Per-pair stage: one-entry output register with pass-through backpressure
                STREAM: begin
                    if (in_hs) begin
                        out_weight   <= new_weight;
                        out_back_err <= back_err;
                        out_last     <= (idx == IDX_W'(N - 1));
                        out_valid    <= 1'b1;
                        idx          <= idx + 1'b1;
                    end else if (out_hs) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        if (out_last) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_backprop784.sv
// Directed bench for neuron_backprop784: nominal stream, saturation, floor rounding,
// backpressure, start-while-busy and reset mid-stream.
module tb_neuron_backprop784;

    localparam int N = 784;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] err_in = '0, sigma_prime = '0, bias_in = '0, lr = '0;
    logic        busy, done;
    logic [31:0] delta_out, bias_out;
    logic        in_valid = 1'b0, in_ready;
    logic [31:0] in_activ = '0, in_weight = '0;
    logic        out_valid, out_ready = 1'b0;
    logic [31:0] out_weight, out_back_err;
    logic        out_last;

    int errors = 0;
    int checks = 0;

    neuron_backprop784 #(.N(N), .W(32), .FRAC(24)) dut (
        .clk(clk), .rst(rst), .start(start),
        .err_in(err_in), .sigma_prime(sigma_prime), .bias_in(bias_in), .lr(lr),
        .busy(busy), .done(done), .delta_out(delta_out), .bias_out(bias_out),
        .in_valid(in_valid), .in_ready(in_ready), .in_activ(in_activ), .in_weight(in_weight),
        .out_valid(out_valid), .out_ready(out_ready), .out_weight(out_weight),
        .out_back_err(out_back_err), .out_last(out_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Weight pattern: 0 = constant 2.0, 1 = distinct signed value per index.
    function automatic logic [31:0] wgen(input int pat, input int i);
        int w;
        w = (i - 400) * 1048576;
        return (pat == 0) ? 32'h0200_0000 : w;
    endfunction

    // With delta=0.25, lr=0.5, a=1.0: new w = w - 0.125, back err = w/4.
    function automatic logic [31:0] exp_w(input int pat, input int i);
        return wgen(pat, i) - 32'h0020_0000;
    endfunction

    function automatic logic [31:0] exp_be(input int pat, input int i);
        logic signed [31:0] w;
        w = wgen(pat, i);
        return w >>> 2;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_last", {31'b0, out_last}, 32'd0);
        chk("rst_delta", delta_out, 32'd0);
        chk("rst_bias", bias_out, 32'd0);
        chk("rst_out_weight", out_weight, 32'd0);
        chk("rst_out_back_err", out_back_err, 32'd0);
    endtask

    task automatic do_start(input logic [31:0] e, input logic [31:0] s,
                            input logic [31:0] b, input logic [31:0] l);
        start = 1'b1; err_in = e; sigma_prime = s; bias_in = b; lr = l;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", {31'b0, busy}, 32'd1);
        @(negedge clk);
    endtask

    // Streams pairs cycle by cycle, checking every visible output against the model.
    task automatic stream(input int pat, input int rmode, input int stop_after,
                          input bit poke_start, output int cyc);
        int  ic, oc;
        bit  fin, ihs, ohs;
        ic = 0; oc = 0; cyc = 0; fin = 0;
        while (!fin && cyc < 5000) begin
            in_valid  = 1'b1;
            in_activ  = 32'h0100_0000;
            in_weight = (ic < N) ? wgen(pat, ic) : 32'hDEAD_BEEF;
            if (rmode == 0)
                out_ready = 1'b1;
            else if (cyc >= 10 && cyc < 15)
                out_ready = 1'b0;
            else
                out_ready = 1'($urandom_range(0, 1));
            start  = poke_start && (cyc == 20);
            err_in = 32'h7F00_0000;
            #1;
            if (out_valid) begin
                chk($sformatf("out_weight[%0d]", oc), out_weight, exp_w(pat, oc));
                chk($sformatf("out_back_err[%0d]", oc), out_back_err, exp_be(pat, oc));
                chk($sformatf("out_last[%0d]", oc), {31'b0, out_last}, {31'b0, oc == N - 1});
                if (!out_ready)
                    chk($sformatf("stall_in_ready[%0d]", oc), {31'b0, in_ready}, 32'd0);
            end
            if (ic >= N)
                chk("in_ready_after_N", {31'b0, in_ready}, 32'd0);
            ihs = in_valid && in_ready;
            ohs = out_valid && out_ready;
            @(negedge clk);
            if (ihs) ic++;
            if (ohs) begin
                oc++;
                if (oc == N || oc == stop_after) fin = 1;
            end
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b0; start = 1'b0;
        chk("stream_completed", {31'b0, fin}, 32'd1);
    endtask

    task automatic finish_pass();
        chk("done_pulse", {31'b0, done}, 32'd1);
        chk("busy_in_done", {31'b0, busy}, 32'd1);
        @(negedge clk);
        chk("done_cleared", {31'b0, done}, 32'd0);
        chk("idle_after_done", {31'b0, busy}, 32'd0);
    endtask

    initial begin
        int cyc;
        @(negedge clk);
        @(negedge clk);
        do_reset();

        // Nominal pass: constant pairs, full throughput
        do_start(32'h0100_0000, 32'h0040_0000, 32'h0100_0000, 32'h0080_0000);
        chk("nom_delta", delta_out, 32'h0040_0000);
        chk("nom_bias", bias_out, 32'h00E0_0000);
        stream(0, 0, N, 0, cyc);
        chk("nom_back_to_back_cycles", cyc, N + 1);
        finish_pass();
        chk("nom_delta_hold", delta_out, 32'h0040_0000);
        chk("nom_bias_hold", bias_out, 32'h00E0_0000);

        // Backpressure with distinct per-index weights
        do_start(32'h0100_0000, 32'h0040_0000, 32'h0100_0000, 32'h0080_0000);
        stream(1, 1, N, 0, cyc);
        finish_pass();

        // Start pulsed mid-stream with a different err_in must be ignored
        do_start(32'h0100_0000, 32'h0040_0000, 32'h0100_0000, 32'h0080_0000);
        stream(1, 0, N, 1, cyc);
        finish_pass();
        chk("busy_start_delta", delta_out, 32'h0040_0000);

        // Saturating multiply and saturating bias subtraction
        do_start(32'h7F00_0000, 32'h7F00_0000, 32'h8000_0000, 32'h0080_0000);
        chk("sat_delta", delta_out, 32'h7FFF_FFFF);
        chk("sat_bias", bias_out, 32'h8000_0000);
        do_reset();

        // Floor rounding of a negative product
        do_start(32'hFFFF_FFFF, 32'h0080_0000, 32'h0100_0000, 32'h0080_0000);
        chk("floor_delta", delta_out, 32'hFFFF_FFFF);
        chk("floor_bias", bias_out, 32'h0100_0001);
        do_reset();

        // Reset after two outputs, then a clean pass
        do_start(32'h0100_0000, 32'h0040_0000, 32'h0100_0000, 32'h0080_0000);
        stream(1, 0, 2, 0, cyc);
        do_reset();
        do_start(32'h0100_0000, 32'h0040_0000, 32'h0100_0000, 32'h0080_0000);
        chk("post_rst_delta", delta_out, 32'h0040_0000);
        stream(1, 1, N, 0, cyc);
        finish_pass();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
